// File: rtl/cpu_defs_pkg.sv
// rtl/cpu_defs_pkg.sv - shared encodings for the instruction sequencer and datapath
package cpu_defs;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_XOR = 3'b100;
    localparam logic [2:0] ALU_NOT = 3'b101;
    localparam logic [2:0] ALU_SHL = 3'b110;
    localparam logic [2:0] ALU_SHR = 3'b111;

    localparam logic [2:0] SUB_LDI  = 3'b000;
    localparam logic [2:0] SUB_JMP  = 3'b001;
    localparam logic [2:0] SUB_BZ   = 3'b010;
    localparam logic [2:0] SUB_BC   = 3'b011;
    localparam logic [2:0] SUB_HALT = 3'b100;
    localparam logic [2:0] SUB_NOP  = 3'b101;

    localparam int CLS_BIT = 15;
    localparam int OPC_MSB = 14;
    localparam int OPC_LSB = 12;
    localparam int RD_MSB  = 11;
    localparam int RD_LSB  = 8;
    localparam int RA_MSB  = 7;
    localparam int RA_LSB  = 4;
    localparam int RB_MSB  = 3;
    localparam int RB_LSB  = 0;
    localparam int IMM_MSB = 7;
    localparam int IMM_LSB = 0;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_HALT   = 3'd4
    } state_t;

    typedef struct packed {
        logic [2:0] opcode;
        logic [3:0] rd;
        logic [3:0] ra;
        logic [3:0] rb;
        logic [7:0] imm;
        logic       is_alu;
        logic       is_ldi;
        logic       is_jmp;
        logic       is_branch;
        logic       branch_on_carry;
        logic       is_halt;
        logic       is_illegal;
    } decode_t;

endpackage

// File: rtl/instr_decode.sv
// rtl/instr_decode.sv - combinational split of a 16-bit instruction into fields and class flags
module instr_decode
    import cpu_defs::*;
(
    input  logic [15:0] instr,
    output decode_t     dec
);

    always_comb begin
        dec        = '0;
        dec.opcode = instr[OPC_MSB:OPC_LSB];
        dec.rd     = instr[RD_MSB:RD_LSB];
        dec.ra     = instr[RA_MSB:RA_LSB];
        dec.rb     = instr[RB_MSB:RB_LSB];
        dec.imm    = instr[IMM_MSB:IMM_LSB];
        if (!instr[CLS_BIT]) begin
            dec.is_alu = 1'b1;
        end else begin
            case (instr[OPC_MSB:OPC_LSB])
                SUB_LDI:  dec.is_ldi = 1'b1;
                SUB_JMP:  dec.is_jmp = 1'b1;
                SUB_BZ:   dec.is_branch = 1'b1;
                SUB_BC: begin
                    dec.is_branch       = 1'b1;
                    dec.branch_on_carry = 1'b1;
                end
                SUB_HALT: dec.is_halt = 1'b1;
                SUB_NOP:  ;
                // Reserved sub-ops behave as NOP but are flagged.
                default:  dec.is_illegal = 1'b1;
            endcase
        end
    end

endmodule

// File: rtl/control_unit.sv
// rtl/control_unit.sv - fetch/decode/exec sequencer driving the register file and ALU
module control_unit
    import cpu_defs::*;
#(
    parameter int PC_W    = 8,
    parameter int INSTR_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    output logic [PC_W-1:0]    imem_addr,
    input  logic [INSTR_W-1:0] imem_data,
    input  logic               alu_zero,
    input  logic               alu_carry,
    output logic [2:0]         alu_opcode,
    output logic [3:0]         ra_addr,
    output logic [3:0]         rb_addr,
    output logic [3:0]         write_addr,
    output logic [7:0]         user_write_data,
    output logic               write_en,
    output logic               alu_en,
    output logic               halted,
    output logic               illegal,
    output logic [PC_W-1:0]    pc
);

    state_t             state_q, state_d;
    logic [PC_W-1:0]    pc_q, pc_d;
    logic [PC_W-1:0]    imem_addr_q, imem_addr_d;
    logic [INSTR_W-1:0] instr_q, instr_d;
    logic               zero_q, zero_d;
    logic               carry_q, carry_d;
    logic               illegal_q, illegal_d;
    logic [PC_W-1:0]    next_pc;
    logic               take_branch;
    decode_t            dec;

    // Decoding the latched word keeps every datapath field stable through EXEC.
    instr_decode u_decode (
        .instr (instr_q),
        .dec   (dec)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            pc_q        <= '0;
            imem_addr_q <= '0;
            instr_q     <= '0;
            zero_q      <= 1'b0;
            carry_q     <= 1'b0;
            illegal_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            imem_addr_q <= imem_addr_d;
            instr_q     <= instr_d;
            zero_q      <= zero_d;
            carry_q     <= carry_d;
            illegal_q   <= illegal_d;
        end
    end

    always_comb begin
        take_branch = dec.is_jmp ||
                      (dec.is_branch && (dec.branch_on_carry ? carry_q : zero_q));
        next_pc     = take_branch ? PC_W'(dec.imm) : pc_q + 1'b1;
    end

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        imem_addr_d = imem_addr_q;
        instr_d     = instr_q;
        zero_d      = zero_q;
        carry_d     = carry_q;
        illegal_d   = illegal_q;
        write_en    = 1'b0;
        alu_en      = 1'b0;
        case (state_q)
            ST_IDLE, ST_HALT: begin
                if (start) begin
                    state_d     = ST_FETCH;
                    pc_d        = '0;
                    imem_addr_d = '0;
                    illegal_d   = 1'b0;
                end
            end
            ST_FETCH: state_d = ST_DECODE;
            ST_DECODE: begin
                instr_d = imem_data;
                state_d = ST_EXEC;
            end
            ST_EXEC: begin
                if (dec.is_alu) begin
                    write_en = 1'b1;
                    alu_en   = 1'b1;
                    zero_d   = alu_zero;
                    carry_d  = alu_carry;
                end
                if (dec.is_ldi) begin
                    write_en = 1'b1;
                end
                if (dec.is_illegal) begin
                    illegal_d = 1'b1;
                end
                // HALT leaves pc on itself so software can see where it stopped.
                if (dec.is_halt) begin
                    state_d = ST_HALT;
                end else begin
                    state_d     = ST_FETCH;
                    pc_d        = next_pc;
                    imem_addr_d = next_pc;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign imem_addr       = imem_addr_q;
    assign pc              = pc_q;
    assign illegal         = illegal_q;
    assign halted          = (state_q == ST_IDLE) || (state_q == ST_HALT);
    assign alu_opcode      = dec.opcode;
    assign ra_addr         = dec.ra;
    assign rb_addr         = dec.rb;
    assign write_addr      = dec.rd;
    assign user_write_data = dec.imm;

endmodule

// File: tb/tb_control_unit.sv
// tb/tb_control_unit.sv - directed self-checking bench with ROM and datapath models
module tb_control_unit;
    import cpu_defs::*;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  imem_addr;
    logic [15:0] imem_data = 16'h0;
    logic        alu_zero, alu_carry;
    logic [2:0]  alu_opcode;
    logic [3:0]  ra_addr, rb_addr, write_addr;
    logic [7:0]  user_write_data;
    logic        write_en, alu_en, halted, illegal;
    logic [7:0]  pc;

    logic [15:0] rom [0:255];
    logic [7:0]  regs [0:15];
    logic [7:0]  alu_r;
    logic        alu_c;
    int          cyc = 0;
    int          start_cyc = 0;
    int          checks = 0;
    int          errors = 0;
    int          we_log [$];

    control_unit #(.PC_W(8), .INSTR_W(16)) dut (
        .clk(clk), .rst(rst), .start(start),
        .imem_addr(imem_addr), .imem_data(imem_data),
        .alu_zero(alu_zero), .alu_carry(alu_carry),
        .alu_opcode(alu_opcode), .ra_addr(ra_addr), .rb_addr(rb_addr),
        .write_addr(write_addr), .user_write_data(user_write_data),
        .write_en(write_en), .alu_en(alu_en), .halted(halted),
        .illegal(illegal), .pc(pc)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) imem_data <= rom[imem_addr];

    always_comb begin
        {alu_c, alu_r} = 9'h0;
        case (alu_opcode)
            ALU_ADD: {alu_c, alu_r} = {1'b0, regs[ra_addr]} + {1'b0, regs[rb_addr]};
            ALU_SUB: {alu_c, alu_r} = {1'b0, regs[ra_addr]} - {1'b0, regs[rb_addr]};
            ALU_AND: alu_r = regs[ra_addr] & regs[rb_addr];
            ALU_OR:  alu_r = regs[ra_addr] | regs[rb_addr];
            ALU_XOR: alu_r = regs[ra_addr] ^ regs[rb_addr];
            ALU_NOT: alu_r = ~regs[ra_addr];
            ALU_SHL: {alu_c, alu_r} = {regs[ra_addr], 1'b0};
            ALU_SHR: {alu_r, alu_c} = {1'b0, regs[ra_addr]};
            default: {alu_c, alu_r} = 9'h0;
        endcase
    end
    assign alu_zero  = (alu_r == 8'h00);
    assign alu_carry = alu_c;

    always @(posedge clk)
        if (write_en && write_addr != 4'd0)
            regs[write_addr] <= alu_en ? alu_r : user_write_data;

    always @(negedge clk) if (write_en === 1'b1) we_log.push_back(cyc - start_cyc);

    task automatic clear_all();
        for (int i = 0; i < 256; i++) rom[i] = 16'hC000;
        for (int i = 0; i < 16; i++) regs[i] = 8'h00;
        we_log.delete();
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Returns at the negedge of the FETCH cycle that follows the start edge.
    task automatic do_start();
        @(negedge clk);
        start = 1'b1;
        start_cyc = cyc;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_halt(input int max_cycles);
        for (int i = 0; i < max_cycles && halted !== 1'b1; i++) @(negedge clk);
        checks++;
        if (halted !== 1'b1) begin
            $display("FAIL halt_timeout: halted=%b required 1", halted);
            errors++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        step(2);
        checks++; if (halted !== 1'b1) begin $display("FAIL rst_halted: got %b need 1", halted); errors++; end
        checks++; if (pc !== 8'h00) begin $display("FAIL rst_pc: got %h need 00", pc); errors++; end
        checks++; if (imem_addr !== 8'h00) begin $display("FAIL rst_imem_addr: got %h need 00", imem_addr); errors++; end
        checks++; if (write_en !== 1'b0) begin $display("FAIL rst_write_en: got %b need 0", write_en); errors++; end
        checks++; if (alu_en !== 1'b0) begin $display("FAIL rst_alu_en: got %b need 0", alu_en); errors++; end
        checks++; if (illegal !== 1'b0) begin $display("FAIL rst_illegal: got %b need 0", illegal); errors++; end
        checks++;
        if ({alu_opcode, ra_addr, rb_addr, write_addr, user_write_data} !== 23'h0) begin
            $display("FAIL rst_fields: got %h need 0", {alu_opcode, ra_addr, rb_addr, write_addr, user_write_data});
            errors++;
        end
        rst = 1'b1;
        step(2);
        checks++; if (halted !== 1'b1) begin $display("FAIL idle_no_start: got %b need 1", halted); errors++; end
    endtask

    task automatic test_ldi_add();
        clear_all();
        rom[0] = 16'h8105; rom[1] = 16'h8203; rom[2] = 16'h0312; rom[3] = 16'hC000;
        do_start();
        checks++; if (halted !== 1'b0) begin $display("FAIL add_running: got %b need 0", halted); errors++; end
        wait_halt(60);
        checks++; if (regs[3] !== 8'h08) begin $display("FAIL add_r3: got %h need 08", regs[3]); errors++; end
        checks++; if (pc !== 8'h03) begin $display("FAIL add_pc: got %h need 03", pc); errors++; end
        checks++;
        if (we_log.size() != 3 || we_log[0] != 3 || we_log[1] != 6 || we_log[2] != 9) begin
            $display("FAIL add_we_cycles: got %p need '{3,6,9}", we_log);
            errors++;
        end
    endtask

    task automatic test_bz();
        clear_all();
        rom[0] = 16'h8100; rom[1] = 16'h1411; rom[2] = 16'hA005; rom[3] = 16'h85EE;
        rom[4] = 16'hC000; rom[5] = 16'h8677; rom[6] = 16'hC000;
        regs[4] = 8'h99; regs[5] = 8'h55;
        do_start();
        wait_halt(80);
        checks++; if (regs[4] !== 8'h00) begin $display("FAIL bz_r4: got %h need 00", regs[4]); errors++; end
        checks++; if (regs[5] !== 8'h55) begin $display("FAIL bz_r5: got %h need 55", regs[5]); errors++; end
        checks++; if (regs[6] !== 8'h77) begin $display("FAIL bz_r6: got %h need 77", regs[6]); errors++; end
        checks++; if (pc !== 8'h06) begin $display("FAIL bz_pc: got %h need 06", pc); errors++; end
    endtask

    task automatic test_bc();
        clear_all();
        rom[0] = 16'h81FF; rom[1] = 16'h8201; rom[2] = 16'h0312; rom[3] = 16'hB007;
        rom[7] = 16'hA009;
        do_start();
        wait_halt(80);
        checks++; if (regs[3] !== 8'h00) begin $display("FAIL bc_r3: got %h need 00", regs[3]); errors++; end
        checks++; if (pc !== 8'h09) begin $display("FAIL bc_taken_pc: got %h need 09", pc); errors++; end
        clear_all();
        rom[0] = 16'h8101; rom[1] = 16'h8201; rom[2] = 16'h0312; rom[3] = 16'hB007;
        do_start();
        wait_halt(80);
        checks++; if (regs[3] !== 8'h02) begin $display("FAIL bc_nt_r3: got %h need 02", regs[3]); errors++; end
        checks++; if (pc !== 8'h04) begin $display("FAIL bc_not_taken_pc: got %h need 04", pc); errors++; end
    endtask

    task automatic test_wrap();
        clear_all();
        rom[0] = 16'h90FF; rom[255] = 16'hD000;
        do_start();
        step(3);
        checks++; if (pc !== 8'hFF) begin $display("FAIL jmp_pc: got %h need ff", pc); errors++; end
        checks++; if (imem_addr !== 8'hFF) begin $display("FAIL jmp_imem: got %h need ff", imem_addr); errors++; end
        step(3);
        checks++; if (pc !== 8'h00) begin $display("FAIL wrap_pc: got %h need 00", pc); errors++; end
        checks++; if (imem_addr !== 8'h00) begin $display("FAIL wrap_imem: got %h need 00", imem_addr); errors++; end
        step(3);
        checks++; if (pc !== 8'hFF) begin $display("FAIL rejmp_pc: got %h need ff", pc); errors++; end
        checks++; if (we_log.size() != 0) begin $display("FAIL wrap_we: got %0d pulses need 0", we_log.size()); errors++; end
        rst = 1'b0;
        step(1);
        rst = 1'b1;
    endtask

    task automatic test_illegal();
        clear_all();
        rom[0] = 16'hE000; rom[1] = 16'hC000;
        do_start();
        wait_halt(60);
        checks++; if (illegal !== 1'b1) begin $display("FAIL ill_set: got %b need 1", illegal); errors++; end
        checks++; if (pc !== 8'h01) begin $display("FAIL ill_pc: got %h need 01", pc); errors++; end
        checks++; if (we_log.size() != 0) begin $display("FAIL ill_we: got %0d pulses need 0", we_log.size()); errors++; end
        do_start();
        checks++; if (illegal !== 1'b0) begin $display("FAIL ill_clear: got %b need 0", illegal); errors++; end
        step(2);
        checks++; if (illegal !== 1'b0) begin $display("FAIL ill_exec: got %b need 0", illegal); errors++; end
        step(1);
        checks++; if (illegal !== 1'b1) begin $display("FAIL ill_reset: got %b need 1", illegal); errors++; end
        wait_halt(20);
    endtask

    task automatic test_reset_mid();
        clear_all();
        rom[0] = 16'h8105; rom[1] = 16'h8203; rom[2] = 16'h0312; rom[3] = 16'hC000;
        regs[3] = 8'hAA;
        do_start();
        step(8);
        checks++; if (write_en !== 1'b1 || alu_en !== 1'b1) begin $display("FAIL mid_exec: got we=%b ae=%b need 1 1", write_en, alu_en); errors++; end
        #2 rst = 1'b0;
        #1;
        checks++; if (write_en !== 1'b0) begin $display("FAIL mid_we: got %b need 0", write_en); errors++; end
        checks++; if (halted !== 1'b1) begin $display("FAIL mid_halted: got %b need 1", halted); errors++; end
        checks++; if (pc !== 8'h00) begin $display("FAIL mid_pc: got %h need 00", pc); errors++; end
        step(1);
        checks++; if (regs[3] !== 8'hAA) begin $display("FAIL mid_r3: got %h need aa", regs[3]); errors++; end
        rst = 1'b1;
        step(1);
    endtask

    initial begin
        test_reset();
        test_ldi_add();
        test_bz();
        test_bc();
        test_wrap();
        test_illegal();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/control_unit.md
Name: control_unit

Overview:
- Instruction sequencer directly upstream of the datapath (16x8 register file + 8-op ALU).
- Fetches 16-bit instructions from a synchronous-read instruction ROM, decodes them, and drives the datapath's alu_opcode, ra_addr, rb_addr, write_addr, user_write_data, write_en and alu_en.
- Captures alu_zero/alu_carry into flag registers for conditional branches.
- Provides start/halted handshake toward the top level.

Parameters:
PC_W, 8, program counter / ROM address width
INSTR_W, 16, instruction width (fixed encoding below; other values unsupported)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-low reset
start  in  1  pulse; leaves IDLE or HALT and begins fetching at pc=0
imem_addr  out  PC_W  ROM address (registered)
imem_data  in  16  ROM data, valid one cycle after imem_addr
alu_zero  in  1  datapath ALU zero flag (combinational from current ra/rb/opcode)
alu_carry  in  1  datapath ALU carry flag
alu_opcode  out  3  ALU op to datapath
ra_addr  out  4  read port A address
rb_addr  out  4  read port B address
write_addr  out  4  register write address
user_write_data  out  8  immediate for LDI
write_en  out  1  register write strobe, one cycle
alu_en  out  1  selects ALU result as write data
halted  out  1  high in IDLE and HALT
illegal  out  1  sticky; set on reserved opcode, cleared by reset or start
pc  out  PC_W  current program counter

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE. pc, imem_addr, flags, alu_opcode, ra/rb/write_addr and user_write_data are 0. write_en, alu_en and illegal are 0. halted=1.
- Encoding:
  - bit15=0: ALU op. [14:12]=alu_opcode, [11:8]=rd, [7:4]=ra, [3:0]=rb.
  - bit15=1: [14:12] sub-op.
    - 000 LDI: rd[11:8] <= imm[7:0].
    - 001 JMP: target [7:0].
    - 010 BZ: branch to target if zero flag is set.
    - 011 BC: branch to target if carry flag is set.
    - 100 HALT.
    - 101 NOP.
    - 110/111 reserved: execute as NOP and set illegal.
- FSM: IDLE -> FETCH -> DECODE -> EXEC -> FETCH ..., plus HALT.
  - IDLE/HALT: outputs quiescent. On start: pc=0, imem_addr=0, illegal=0, go to FETCH.
  - FETCH: imem_addr holds pc. ROM data is returned next cycle.
  - DECODE: latch imem_data. Register alu_opcode, ra_addr, rb_addr, write_addr and user_write_data from it. These stay stable through EXEC.
  - EXEC (exactly one cycle):
    - ALU op: write_en=1, alu_en=1. Zero/carry flags <= alu_zero/alu_carry at the end of the cycle.
    - LDI: write_en=1, alu_en=0. Flags unchanged.
    - JMP, taken BZ/BC: pc <= target. Otherwise pc <= pc+1, wrapping from 2^PC_W-1 to 0.
    - HALT: go to HALT and leave pc pointing at the HALT instruction.
    - All other instructions return to FETCH, with imem_addr updated to the next pc.
- Throughput: 3 cycles per instruction. Register writes become visible to the next instruction, whose EXEC is 3 cycles later, so no forwarding is needed.
- write_en and alu_en are asserted only in EXEC and are 0 in every other state.
- Destination rd=0 is issued normally; the datapath discards writes to reg0.
- start is ignored while in FETCH, DECODE or EXEC.
- Reset mid-instruction aborts immediately: write_en drops asynchronously and no partial write occurs after rst asserts.
- Branches test the flags latched by the most recent ALU instruction. LDI, JMP and NOP do not modify flags.

Decomposition:
- Shared package (cpu_defs): ALU opcode constants ADD..SHR (000..111, matching the datapath), sub-op constants LDI/JMP/BZ/BC/HALT/NOP, FSM state encoding, and instruction field bit positions.
- One natural sub-module, instr_decode: combinational split of the 16-bit word into fields plus is_alu/is_ldi/is_branch/is_halt/is_illegal. The FSM, pc and flag registers stay in control_unit.

Test Plan:
- Reset, then start with ROM {0x8105 (LDI r1,5), 0x8203 (LDI r2,3), 0x0312 (ADD r3,r1,r2), 0xC000 (HALT)} and a real datapath -> r3=0x08. write_en pulses at cycles 3, 6, 9 after start. halted=1 with pc=3.
- ROM {LDI r1,0x00; SUB r4,r1,r1; BZ 0x05; LDI r5,0xEE; HALT; LDI r6,0x77 at 5; HALT} -> branch taken, r5 untouched, r6=0x77, final pc=6.
- ROM {LDI r1,0xFF; LDI r2,0x01; ADD r3,r1,r2; BC 0x07; ...} -> carry=1, zero=1, branch to 7. Also a non-taken BC case with 0x01+0x01 falls through to pc+1.
- JMP 0xFF at address 0, NOP at 0xFF -> pc wraps to 0x00 after the NOP and re-executes the JMP. Check imem_addr=0x00 in the following FETCH.
- Reserved word 0xE000 -> illegal=1, no write_en pulse, pc advances by 1. A subsequent start clears illegal.
- Assert rst low mid-EXEC of an ALU op -> write_en=0 immediately, halted=1, pc=0, destination register unchanged.
